// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: command codes and the
// sequencer state encoding.
package lcd_pkg;

   localparam logic [3:0] CMD_WRITE = 4'd0;
   localparam logic [3:0] CMD_UP    = 4'd1;
   localparam logic [3:0] CMD_DOWN  = 4'd2;
   localparam logic [3:0] CMD_LEFT  = 4'd3;
   localparam logic [3:0] CMD_RIGHT = 4'd4;
   localparam logic [3:0] CMD_MAX   = 4'd5;
   localparam logic [3:0] CMD_MIN   = 4'd6;
   localparam logic [3:0] CMD_AVG   = 4'd7;
   localparam logic [3:0] CMD_CCW   = 4'd8;
   localparam logic [3:0] CMD_CW    = 4'd9;
   localparam logic [3:0] CMD_MIRX  = 4'd10;
   localparam logic [3:0] CMD_MIRY  = 4'd11;
   localparam logic [3:0] CMD_NOP   = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE,
      ST_WAIT_DONE,
      ST_FINISH
   } seq_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with explicit occupancy count and full/empty flags.
// Head is read combinationally; DEPTH must be a power of two.
module lcd_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   // NOTE: the storage array has no reset; pointers and count define which
   // entries are valid, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/lcd_cmd_seq.sv
// Host-to-LCD-controller command sequencer: buffers host commands and issues
// them one at a time under the controller's busy handshake until a write.
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int               FIFO_DEPTH = 8,
   parameter int               CMD_W      = 4,
   parameter logic [CMD_W-1:0] NOP_CMD    = CMD_NOP,
   parameter logic [CMD_W-1:0] WRITE_CMD  = CMD_WRITE,
   parameter int               BUSY_TO    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CMD_W-1:0]            in_cmd,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [CMD_W-1:0]            cmd,
   output logic                        cmd_valid,
   input  logic                        busy,
   input  logic                        lcd_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [7:0]                  issued_cnt,
   output logic                        seq_done,
   output logic                        err
);

   localparam int BCW = $clog2(BUSY_TO + 1);
   localparam logic [BCW-1:0] BUSY_LAST = BCW'(BUSY_TO - 1);

   seq_state_e       state_q;
   logic [CMD_W-1:0] cmd_q;
   logic             cmd_valid_q;
   logic [7:0]       issued_cnt_q;
   logic             seq_done_q;
   logic             err_q;
   logic             write_seen_q;
   logic [BCW-1:0]   busy_cnt_q;

   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CMD_W-1:0] head;

   assign in_ready = !full && !write_seen_q;
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == ST_IDLE) && !empty && !busy;

   lcd_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (in_cmd),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (fifo_count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cmd_q        <= NOP_CMD;
         cmd_valid_q  <= 1'b0;
         issued_cnt_q <= 8'd0;
         seq_done_q   <= 1'b0;
         err_q        <= 1'b0;
         write_seen_q <= 1'b0;
         busy_cnt_q   <= '0;
      end else begin
         if (push && (in_cmd == WRITE_CMD)) write_seen_q <= 1'b1;

         // The strobe and its command last exactly one cycle by default.
         cmd_q       <= NOP_CMD;
         cmd_valid_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  cmd_q       <= head;
                  cmd_valid_q <= 1'b1;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issued_cnt_q != 8'hFF) issued_cnt_q <= issued_cnt_q + 8'd1;
               busy_cnt_q <= '0;
               state_q    <= (cmd_q == WRITE_CMD) ? ST_WAIT_DONE : ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (busy) begin
                  state_q <= ST_WAIT_IDLE;
               end else if (busy_cnt_q == BUSY_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  busy_cnt_q <= busy_cnt_q + 1'b1;
               end
            end
            ST_WAIT_IDLE: begin
               if (!busy) state_q <= ST_IDLE;
            end
            ST_WAIT_DONE: begin
               if (lcd_done) begin
                  seq_done_q <= 1'b1;
                  state_q    <= ST_FINISH;
               end
            end
            ST_FINISH: state_q <= ST_FINISH;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd        = cmd_q;
   assign cmd_valid  = cmd_valid_q;
   assign issued_cnt = issued_cnt_q;
   assign seq_done   = seq_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: busy gating, throughput, FIFO full,
// sequence completion, busy timeout and mid-operation reset.
module tb_lcd_cmd_seq;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in_cmd = 4'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       busy;
   logic       lcd_done = 1'b0;
   logic [3:0] fifo_count;
   logic [7:0] issued_cnt;
   logic       seq_done;
   logic       err;

   logic busy_drv = 1'b0;
   logic model_en = 1'b0;
   logic busy_m = 1'b0;
   logic prev_strobe = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int nop_viol = 0;
   logic [3:0] log_cmd[$];
   int         log_cyc[$];

   lcd_cmd_seq dut (
      .clk        (clk),
      .reset      (reset),
      .in_cmd     (in_cmd),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .busy       (busy),
      .lcd_done   (lcd_done),
      .fifo_count (fifo_count),
      .issued_cnt (issued_cnt),
      .seq_done   (seq_done),
      .err        (err)
   );

   assign busy = model_en ? busy_m : busy_drv;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Controller model and strobe log: busy rises the cycle after a strobe
   // and falls one cycle later.
   always @(negedge clk) begin
      busy_m = prev_strobe;
      prev_strobe = cmd_valid;
      if (cmd_valid) begin
         log_cmd.push_back(cmd);
         log_cyc.push_back(cyc);
      end else if (cmd !== CMD_NOP) begin
         nop_viol++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] c);
      in_cmd   = c;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      lcd_done = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_log(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && log_cmd.size() < n; i++) step();
      check(tag, 32'(log_cmd.size() >= n), 32'd1);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step();
   endtask

   initial begin
      int base;
      int s;

      // Reset values, then busy held high while three commands are queued.
      busy_drv = 1'b1;
      step();
      check("rst_cmd",       32'(cmd),        32'hF);
      check("rst_cmd_valid", 32'(cmd_valid),  32'd0);
      check("rst_fifo",      32'(fifo_count), 32'd0);
      check("rst_issued",    32'(issued_cnt), 32'd0);
      check("rst_seq_done",  32'(seq_done),   32'd0);
      check("rst_err",       32'(err),        32'd0);
      check("rst_in_ready",  32'(in_ready),   32'd1);
      reset = 1'b0;
      base = log_cmd.size();
      push(4'd3);
      push(4'd4);
      push(4'd0);
      check("ready_after_write", 32'(in_ready),   32'd0);
      check("fifo_busy_hold",    32'(fifo_count), 32'd3);
      repeat (67) step();
      check("no_strobe_busy", 32'(log_cmd.size()), 32'(base));
      model_en = 1'b1;
      wait_log("t1_timeout", base + 3, 40);
      check("t1_cmd0", 32'(log_cmd[base]),     32'd3);
      check("t1_cmd1", 32'(log_cmd[base + 1]), 32'd4);
      check("t1_cmd2", 32'(log_cmd[base + 2]), 32'd0);

      // Completion: lcd_done 20 cycles after the write strobe.
      s = log_cyc[base + 2];
      wait_cyc(s + 20);
      check("seq_done_before", 32'(seq_done), 32'd0);
      lcd_done = 1'b1;
      step();
      lcd_done = 1'b0;
      check("seq_done_set", 32'(seq_done), 32'd1);
      in_cmd   = 4'd5;
      in_valid = 1'b1;
      check("ready_refused", 32'(in_ready), 32'd0);
      repeat (10) step();
      in_valid = 1'b0;
      check("seq_done_sticky", 32'(seq_done),       32'd1);
      check("no_strobe_after", 32'(log_cmd.size()), 32'(base + 3));
      check("t1_issued",       32'(issued_cnt),     32'd3);
      check("t1_fifo_empty",   32'(fifo_count),     32'd0);

      // Throughput with the controller model.
      do_reset();
      model_en = 1'b1;
      base = log_cmd.size();
      push(4'd1);
      push(4'd2);
      push(4'd5);
      push(4'd7);
      push(4'd0);
      wait_log("t2_timeout", base + 5, 60);
      check("t2_cmd0", 32'(log_cmd[base]),     32'd1);
      check("t2_cmd1", 32'(log_cmd[base + 1]), 32'd2);
      check("t2_cmd2", 32'(log_cmd[base + 2]), 32'd5);
      check("t2_cmd3", 32'(log_cmd[base + 3]), 32'd7);
      check("t2_cmd4", 32'(log_cmd[base + 4]), 32'd0);
      for (int i = 1; i < 5; i++)
         check("t2_gap", 32'(log_cyc[base + i] - log_cyc[base + i - 1]), 32'd4);
      check("t2_issued_pre", 32'(issued_cnt), 32'd4);
      step();
      check("t2_issued", 32'(issued_cnt), 32'd5);

      // FIFO full: nine back-to-back offers with busy held.
      do_reset();
      model_en = 1'b0;
      busy_drv = 1'b1;
      for (int k = 0; k < 9; k++) begin
         in_cmd   = 4'(k + 1);
         in_valid = 1'b1;
         check("t3_ready", 32'(in_ready), 32'(k < 8));
         step();
      end
      in_valid = 1'b0;
      check("t3_full_count", 32'(fifo_count), 32'd8);
      base = log_cmd.size();
      model_en = 1'b1;
      wait_log("t3_timeout_a", base + 1, 20);
      check("t3_count_7", 32'(fifo_count),     32'd7);
      check("t3_cmd_a",   32'(log_cmd[base]),  32'd1);
      wait_log("t3_timeout_b", base + 2, 20);
      check("t3_count_6", 32'(fifo_count),       32'd6);
      check("t3_cmd_b",   32'(log_cmd[base + 1]), 32'd2);

      // Busy timeout: busy never rises after cmd 5.
      do_reset();
      model_en = 1'b0;
      busy_drv = 1'b0;
      base = log_cmd.size();
      push(4'd5);
      push(4'd6);
      wait_log("t5_timeout_a", base + 1, 10);
      s = log_cyc[base];
      check("t5_cmd_a", 32'(log_cmd[base]), 32'd5);
      wait_cyc(s + 4);
      check("t5_err_pre", 32'(err), 32'd0);
      step();
      check("t5_err_set", 32'(err), 32'd1);
      wait_log("t5_timeout_b", base + 2, 10);
      check("t5_cmd_b",   32'(log_cmd[base + 1]), 32'd6);
      check("t5_reissue", 32'(log_cyc[base + 1]), 32'(s + 6));

      // Asynchronous reset while in WAIT_IDLE with three entries queued.
      do_reset();
      model_en = 1'b0;
      busy_drv = 1'b0;
      base = log_cmd.size();
      push(4'd1);
      wait_log("t6_timeout", base + 1, 10);
      busy_drv = 1'b1;
      push(4'd2);
      push(4'd3);
      push(4'd4);
      step();
      check("t6_fifo_pre",   32'(fifo_count), 32'd3);
      check("t6_issued_pre", 32'(issued_cnt), 32'd1);
      reset = 1'b1;
      #1;
      check("t6_cmd",       32'(cmd),        32'hF);
      check("t6_cmd_valid", 32'(cmd_valid),  32'd0);
      check("t6_fifo",      32'(fifo_count), 32'd0);
      check("t6_issued",    32'(issued_cnt), 32'd0);
      check("t6_seq_done",  32'(seq_done),   32'd0);
      check("t6_err",       32'(err),        32'd0);
      step();
      step();
      reset    = 1'b0;
      busy_drv = 1'b0;
      step();
      check("t6_in_ready",   32'(in_ready),   32'd1);
      check("t6_fifo_after", 32'(fifo_count), 32'd0);
      repeat (10) step();
      check("t6_no_strobe", 32'(log_cmd.size()), 32'(base + 1));

      check("nop_between", 32'(nop_viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
